// File: rtl/cpcs_tx_pkg.sv
// Shared constants and FSM encoding for the CorePCS transmit symbol scheduler.
// The CC insertion feature is built only when CPCS_TX_CC_EN is defined.
package cpcs_tx_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K28_0 = 8'h1C;

  localparam int CC_CNT_W = 16;

  typedef enum logic [3:0] {
    ST_ALIGN_A,
    ST_ALIGN_B,
    ST_IDLE_A,
    ST_IDLE_B,
    ST_SOF,
    ST_DATA,
    ST_EOF,
    ST_CC_A,
    ST_CC_B
  } tx_state_e;

endpackage

// File: rtl/cpcs_tx_cc_timer.sv
// Clock-compensation interval timer: saturating symbol counter whose terminal
// value doubles as the CC-pending flag. Used only when CPCS_TX_CC_EN is defined.
module cpcs_tx_cc_timer
  import cpcs_tx_pkg::*;
#(
  parameter int CC_PERIOD = 1024
) (
  input  logic clk,
  input  logic srst,
  input  logic inc_i,
  input  logic clr_i,
  output logic pending_o
);

  localparam logic [CC_CNT_W-1:0] CNT_LAST = CC_CNT_W'(CC_PERIOD - 1);

  logic [CC_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_LAST)) begin
      cnt_d = cnt_q + CC_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter parks at its last value, so pending holds until cleared.
  assign pending_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/cpcs_tx_sched.sv
// Transmit symbol scheduler feeding the 8b/10b encoder: alignment, idles,
// packet framing and (with CPCS_TX_CC_EN defined) clock-compensation insertion.
module cpcs_tx_sched
  import cpcs_tx_pkg::*;
#(
  parameter int ALIGN_CNT = 16
`ifdef CPCS_TX_CC_EN
  ,
  parameter int CC_PERIOD = 1024,
  parameter int CC_REPS   = 2
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ENABLE,
  input  logic [7:0] TX_DATA,
  input  logic       TX_SOP,
  input  logic       TX_EOP,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] ENC_D,
  output logic       ENC_K,
  output logic       ENC_VAL,
  output logic       LINK_UP,
  output logic       CC_ACTIVE,
  output logic       PROT_ERR
);

  localparam logic [7:0] ALIGN_LAST = 8'(ALIGN_CNT - 1);

  tx_state_e  state_q, state_d;
  logic [7:0] pair_cnt_q, pair_cnt_d;
  logic       first_q, first_d;
  logic [7:0] sym_q, sym_d;
  logic       sym_k_q, sym_k_d;
  logic       enc_val_q;
  logic       link_up_q;
  logic       cc_active_q, cc_active_d;
  logic       prot_err_q, prot_err_d;
  logic       ready;

`ifdef CPCS_TX_CC_EN
  localparam logic [3:0] REPS_LAST = 4'(CC_REPS - 1);

  logic [3:0] rep_cnt_q, rep_cnt_d;
  logic       cc_pending;
  logic       cc_clr;

  cpcs_tx_cc_timer #(
    .CC_PERIOD(CC_PERIOD)
  ) u_cc_timer (
    .clk      (CLK),
    .srst     (RST),
    .inc_i    (ENABLE),
    .clr_i    (cc_clr | ~ENABLE),
    .pending_o(cc_pending)
  );
`endif

  always_comb begin
    state_d     = state_q;
    pair_cnt_d  = pair_cnt_q;
    first_d     = first_q;
    sym_d       = K28_5;
    sym_k_d     = 1'b1;
    cc_active_d = 1'b0;
    prot_err_d  = 1'b0;
    ready       = 1'b0;
`ifdef CPCS_TX_CC_EN
    rep_cnt_d   = rep_cnt_q;
    cc_clr      = 1'b0;
`endif
    case (state_q)
      ST_ALIGN_A: state_d = ST_ALIGN_B;
      ST_ALIGN_B: begin
        sym_d   = D16_2;
        sym_k_d = 1'b0;
        if (pair_cnt_q == ALIGN_LAST) begin
          pair_cnt_d = '0;
          state_d    = ST_IDLE_A;
        end else begin
          pair_cnt_d = pair_cnt_q + 8'd1;
          state_d    = ST_ALIGN_A;
        end
      end
      ST_IDLE_A: state_d = ST_IDLE_B;
      ST_IDLE_B: begin
        sym_d   = D16_2;
        sym_k_d = 1'b0;
        // A beat without SOP here is swallowed and flagged.
        ready      = TX_VALID & ~TX_SOP;
        prot_err_d = TX_VALID & ~TX_SOP;
`ifdef CPCS_TX_CC_EN
        if (cc_pending) begin
          state_d   = ST_CC_A;
          rep_cnt_d = '0;
          cc_clr    = 1'b1;
        end else
`endif
        if (TX_VALID && TX_SOP) begin
          state_d = ST_SOF;
        end else begin
          state_d = ST_IDLE_A;
        end
      end
      ST_SOF: begin
        sym_d   = K27_7;
        first_d = 1'b1;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        ready = 1'b1;
        if (TX_VALID) begin
          sym_d      = TX_DATA;
          sym_k_d    = 1'b0;
          first_d    = 1'b0;
          prot_err_d = TX_SOP & ~first_q;
          if (TX_EOP) begin
            state_d = ST_EOF;
          end
        end else begin
          sym_d = K23_7;
        end
      end
      ST_EOF: begin
        sym_d   = K29_7;
        state_d = ST_IDLE_A;
      end
`ifdef CPCS_TX_CC_EN
      ST_CC_A: begin
        cc_active_d = 1'b1;
        state_d     = ST_CC_B;
      end
      ST_CC_B: begin
        sym_d       = K28_0;
        cc_active_d = 1'b1;
        if (rep_cnt_q == REPS_LAST) begin
          rep_cnt_d = '0;
          state_d   = ST_IDLE_A;
        end else begin
          rep_cnt_d = rep_cnt_q + 4'd1;
          state_d   = ST_CC_A;
        end
      end
`endif
      default: state_d = ST_ALIGN_A;
    endcase
  end

  // Disable behaves like reset so alignment always restarts from pair 0.
  always_ff @(posedge CLK) begin
    if (RST || !ENABLE) begin
      state_q     <= ST_ALIGN_A;
      pair_cnt_q  <= '0;
      first_q     <= 1'b0;
      sym_q       <= 8'h00;
      sym_k_q     <= 1'b0;
      enc_val_q   <= 1'b0;
      link_up_q   <= 1'b0;
      cc_active_q <= 1'b0;
      prot_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pair_cnt_q  <= pair_cnt_d;
      first_q     <= first_d;
      sym_q       <= sym_d;
      sym_k_q     <= sym_k_d;
      enc_val_q   <= 1'b1;
      link_up_q   <= (state_q != ST_ALIGN_A) && (state_q != ST_ALIGN_B);
      cc_active_q <= cc_active_d;
      prot_err_q  <= prot_err_d;
    end
  end

`ifdef CPCS_TX_CC_EN
  always_ff @(posedge CLK) begin
    if (RST || !ENABLE) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`endif

  assign TX_READY  = ready & ENABLE & ~RST;
  assign ENC_D     = sym_q;
  assign ENC_K     = sym_k_q;
  assign ENC_VAL   = enc_val_q;
  assign LINK_UP   = link_up_q;
  assign CC_ACTIVE = cc_active_q;
  assign PROT_ERR  = prot_err_q;

endmodule

// File: tb/tb_cpcs_tx_sched.sv
// Directed bench for cpcs_tx_sched (ALIGN_CNT=4); CC checks run when
// CPCS_TX_CC_EN is defined (CC_PERIOD=32, CC_REPS=2).
module tb_cpcs_tx_sched;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ENABLE;
  logic [7:0] TX_DATA;
  logic       TX_SOP;
  logic       TX_EOP;
  logic       TX_VALID;
  logic       TX_READY;
  logic [7:0] ENC_D;
  logic       ENC_K;
  logic       ENC_VAL;
  logic       LINK_UP;
  logic       CC_ACTIVE;
  logic       PROT_ERR;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  cpcs_tx_sched #(
    .ALIGN_CNT(4)
`ifdef CPCS_TX_CC_EN
    ,
    .CC_PERIOD(32),
    .CC_REPS  (2)
`endif
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ENABLE   (ENABLE),
    .TX_DATA  (TX_DATA),
    .TX_SOP   (TX_SOP),
    .TX_EOP   (TX_EOP),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY),
    .ENC_D    (ENC_D),
    .ENC_K    (ENC_K),
    .ENC_VAL  (ENC_VAL),
    .LINK_UP  (LINK_UP),
    .CC_ACTIVE(CC_ACTIVE),
    .PROT_ERR (PROT_ERR)
  );

  typedef struct {
    bit       realign;
    bit       v;
    bit       s;
    bit       e;
    bit [7:0] d;
    bit       rdy;
    bit [7:0] xd;
    bit       xk;
    bit       xperr;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit v, bit s, bit e, bit [7:0] d, bit rdy,
                              bit [7:0] xd, bit xk, bit xperr);
    vec_t t;
    t.realign = r; t.v = v; t.s = s; t.e = e; t.d = d; t.rdy = rdy;
    t.xd = xd; t.xk = xk; t.xperr = xperr;
    vecs.push_back(t);
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    TX_VALID = 1'b0; TX_SOP = 1'b0; TX_EOP = 1'b0; TX_DATA = 8'h00;
  endtask

  // One disabled edge, then 4 align pairs plus IDLE_A; returns in IDLE_B.
  task automatic realign();
    idle_inputs();
    ENABLE = 1'b0;
    tick();
    ENABLE = 1'b1;
    repeat (9) tick();
  endtask

  // Checks the alignment stream that follows a reset/disable release.
  task automatic check_align(string tag, int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk({tag, "_sym"}, {7'd0, ENC_K, ENC_D}, (i % 2 == 0) ? 16'h01BC : 16'h0050);
      chk({tag, "_link"}, {14'd0, ENC_VAL, LINK_UP}, {14'd0, 1'b1, (i >= 8)});
      $display("%s sym %0d: d=%02h k=%0d link=%0d", tag, i, ENC_D, ENC_K, LINK_UP);
    end
  endtask

  // Idle-to-DATA: offers SOP beat 0x11 from IDLE_B, returns in the second DATA cycle.
  task automatic start_packet();
    TX_VALID = 1'b1; TX_SOP = 1'b1; TX_DATA = 8'h11;
    tick();
    tick();
    tick();
    TX_SOP = 1'b0;
  endtask

  int acc_t2;

  initial begin
    RST = 1'b1; ENABLE = 1'b1;
    idle_inputs();

    // Reset state
    tick();
    chk("rst_enc", {7'd0, ENC_VAL, ENC_K, ENC_D}, 16'h0000);
    chk("rst_flags", {12'd0, LINK_UP, CC_ACTIVE, PROT_ERR, TX_READY}, 16'h0000);
    RST = 1'b0;

    // Alignment: 4 pairs, LINK_UP on the 9th symbol, then idles
    check_align("align", 12);

    // Vector table: packet, pads, stray beat, late SOP, single-byte packet
    add(1, 1, 1, 0, 8'h11, 0, 8'h50, 0, 0);
    add(0, 1, 1, 0, 8'h11, 0, 8'hFB, 1, 0);
    add(0, 1, 1, 0, 8'h11, 1, 8'h11, 0, 0);
    add(0, 1, 0, 0, 8'h22, 1, 8'h22, 0, 0);
    add(0, 1, 0, 1, 8'h33, 1, 8'h33, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'hFD, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'hBC, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'h50, 0, 0);

    add(1, 1, 1, 0, 8'hA1, 0, 8'h50, 0, 0);
    add(0, 1, 1, 0, 8'hA1, 0, 8'hFB, 1, 0);
    add(0, 1, 1, 0, 8'hA1, 1, 8'hA1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 1, 8'hF7, 1, 0);
    add(0, 0, 0, 0, 8'h00, 1, 8'hF7, 1, 0);
    add(0, 1, 0, 1, 8'hB2, 1, 8'hB2, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'hFD, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'hBC, 1, 0);

    add(1, 1, 0, 0, 8'h5A, 1, 8'h50, 0, 1);
    add(0, 0, 0, 0, 8'h00, 0, 8'hBC, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'h50, 0, 0);

    add(1, 1, 1, 0, 8'hC1, 0, 8'h50, 0, 0);
    add(0, 1, 1, 0, 8'hC1, 0, 8'hFB, 1, 0);
    add(0, 1, 1, 0, 8'hC1, 1, 8'hC1, 0, 0);
    add(0, 1, 1, 1, 8'hC2, 1, 8'hC2, 0, 1);
    add(0, 0, 0, 0, 8'h00, 0, 8'hFD, 1, 0);

    add(1, 1, 1, 0, 8'hD1, 0, 8'h50, 0, 0);
    add(0, 1, 1, 0, 8'hD1, 0, 8'hFB, 1, 0);
    add(0, 1, 1, 1, 8'hD1, 1, 8'hD1, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'hFD, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 8'hBC, 1, 0);

    acc_t2 = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].realign) realign();
      TX_VALID = vecs[i].v; TX_SOP = vecs[i].s; TX_EOP = vecs[i].e; TX_DATA = vecs[i].d;
      #1;
      chk("row_ready", {15'd0, TX_READY}, {15'd0, vecs[i].rdy});
      if (i < 8 && TX_VALID && TX_READY) acc_t2++;
      tick();
      chk("row_sym", {7'd0, ENC_K, ENC_D}, {7'd0, vecs[i].xk, vecs[i].xd});
      chk("row_perr", {15'd0, PROT_ERR}, {15'd0, vecs[i].xperr});
      chk("row_vlc", {13'd0, ENC_VAL, LINK_UP, CC_ACTIVE}, 16'h0006);
      $display("row %0d: d=%02h k=%0d perr=%0d rdy=%0d", i, ENC_D, ENC_K, PROT_ERR, vecs[i].rdy);
    end
    chk("pkt_accepts", 16'(acc_t2), 16'd3);

    // ENABLE dropped mid-DATA
    realign();
    start_packet();
    TX_DATA = 8'h22; ENABLE = 1'b0;
    #1;
    chk("dis_ready_now", {15'd0, TX_READY}, 16'h0000);
    tick();
    chk("dis_out", {5'd0, ENC_VAL, LINK_UP, TX_READY, ENC_D}, 16'h0000);
    ENABLE = 1'b1;
    idle_inputs();
    check_align("dis_realign", 10);

    // RST asserted mid-DATA
    realign();
    start_packet();
    TX_DATA = 8'h22; RST = 1'b1;
    #1;
    chk("rst_ready_now", {15'd0, TX_READY}, 16'h0000);
    tick();
    chk("rst_mid_out", {13'd0, ENC_VAL, LINK_UP, TX_READY}, 16'h0000);
    RST = 1'b0;
    idle_inputs();
    check_align("rst_realign", 10);

`ifdef CPCS_TX_CC_EN
    begin
      int starts[$];
      int pos;
      logic prev_cc;
      logic [7:0] cc_exp[4];
      logic [8:0] seq_exp[10];
      logic       seq_cc[10];
      int bad_pad;

      cc_exp[0] = 8'hBC; cc_exp[1] = 8'h1C; cc_exp[2] = 8'hBC; cc_exp[3] = 8'h1C;

      // Continuous idle: periodic BC,1C,BC,1C bursts with CC_ACTIVE
      realign();
      prev_cc = 1'b0;
      pos = 0;
      for (int t = 0; t < 130; t++) begin
        tick();
        if (CC_ACTIVE) begin
          if (!prev_cc) begin
            starts.push_back(t);
            pos = 0;
          end
          if (pos < 4) chk("cc_sym", {7'd0, ENC_K, ENC_D}, {7'd0, 1'b1, cc_exp[pos]});
          pos++;
        end else if (prev_cc) begin
          chk("cc_len", 16'(pos), 16'd4);
          $display("cc burst at %0d len %0d", starts[starts.size()-1], pos);
        end
        prev_cc = CC_ACTIVE;
      end
      chk("cc_bursts_ge3", {15'd0, (starts.size() >= 3)}, 16'h0001);
      for (int k = 1; k < starts.size(); k++) begin
        chk("cc_spacing", {15'd0, (starts[k] - starts[k-1] >= 30) && (starts[k] - starts[k-1] <= 34)},
            16'h0001);
      end

      // Long packet delays CC; a waiting SOP is held until CC completes
      realign();
      TX_VALID = 1'b1; TX_SOP = 1'b1; TX_DATA = 8'hE1;
      tick();
      tick();
      tick();
      idle_inputs();
      bad_pad = 0;
      for (int t = 0; t < 40; t++) begin
        tick();
        if (CC_ACTIVE || ENC_D != 8'hF7 || !ENC_K) bad_pad++;
      end
      chk("long_pkt_pads", 16'(bad_pad), 16'd0);
      TX_VALID = 1'b1; TX_EOP = 1'b1; TX_DATA = 8'hE2;
      tick();
      chk("long_pkt_last", {7'd0, ENC_K, ENC_D}, 16'h00E2);
      TX_EOP = 1'b0; TX_SOP = 1'b1; TX_DATA = 8'hF0;
      seq_exp[0] = 9'h1FD; seq_exp[1] = 9'h1BC; seq_exp[2] = 9'h050; seq_exp[3] = 9'h1BC;
      seq_exp[4] = 9'h11C; seq_exp[5] = 9'h1BC; seq_exp[6] = 9'h11C; seq_exp[7] = 9'h1BC;
      seq_exp[8] = 9'h050; seq_exp[9] = 9'h1FB;
      seq_cc = '{0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
      for (int k = 0; k < 10; k++) begin
        #1;
        chk("ccsop_ready", {15'd0, TX_READY}, 16'h0000);
        tick();
        chk("ccsop_sym", {7'd0, ENC_K, ENC_D}, {7'd0, seq_exp[k]});
        chk("ccsop_active", {15'd0, CC_ACTIVE}, {15'd0, seq_cc[k]});
        $display("ccsop %0d: d=%02h k=%0d cc=%0d", k, ENC_D, ENC_K, CC_ACTIVE);
      end
      idle_inputs();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
